// File: rtl/decimator_ve.sv
`default_nettype none
// ============================================================================
// Module      : decimator_ve
// Description : Block-average decimator by N = 2^L. The optional rounding and
//               saturation path is enabled with macro DECIMATOR_VE_ROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module decimator_ve #(
    parameter int WIDTH    = 16,
    parameter int MAX_LOG2 = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic [3:0]       log2_dec_i,
    output logic [WIDTH-1:0] out_o,
    output logic             valid_o
);

    localparam int c_acc_w = WIDTH + MAX_LOG2 + 1;
    localparam int c_cnt_w = MAX_LOG2 + 1;
    localparam logic [3:0]         c_max_l   = 4'(MAX_LOG2);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t                     r_state, w_state_nx;
    logic signed [c_acc_w-1:0]  r_acc, w_acc_nx, w_sum;
    logic        [c_cnt_w-1:0]  r_cnt, w_cnt_nx, w_last;
    logic        [3:0]          r_l, w_l_eff;
    logic        [WIDTH-1:0]    r_out, w_out_nx, w_result;
    logic                       r_valid, w_valid_nx;

    assign w_l_eff = (log2_dec_i > c_max_l) ? c_max_l : log2_dec_i;
    assign w_last  = (c_cnt_one << r_l) - c_cnt_one;
    assign w_sum   = r_acc + $signed({{(c_acc_w-WIDTH){data_i[WIDTH-1]}}, data_i});

`ifdef DECIMATOR_VE_ROUND_EN
    // One extra bit keeps the half-LSB addition from wrapping before the shift.
    localparam logic [c_acc_w:0] c_rnd_one = (c_acc_w+1)'(1);
    localparam logic signed [c_acc_w:0] c_pos_lim =
        $signed({{(c_acc_w-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}});
    localparam logic signed [c_acc_w:0] c_neg_lim =
        $signed({{(c_acc_w-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}});

    logic signed [c_acc_w:0] w_half, w_rnd_sum, w_rnd_shr;

    assign w_half    = (r_l == 4'd0) ? '0 : $signed(c_rnd_one << (r_l - 4'd1));
    assign w_rnd_sum = $signed({w_sum[c_acc_w-1], w_sum}) + w_half;
    assign w_rnd_shr = w_rnd_sum >>> r_l;

    always_comb begin
        w_result = w_rnd_shr[WIDTH-1:0];
        if (w_rnd_shr > c_pos_lim) begin
            w_result = c_pos_lim[WIDTH-1:0];
        end else if (w_rnd_shr < c_neg_lim) begin
            w_result = c_neg_lim[WIDTH-1:0];
        end
    end
`else
    assign w_result = WIDTH'(w_sum >>> r_l);
`endif

    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_cnt_nx   = r_cnt;
        w_out_nx   = r_out;
        w_valid_nx = 1'b0;
        if (w_l_eff != r_l) begin
            // Ratio change: drop the partial block and the sample on this edge.
            w_state_nx = S_IDLE;
            w_acc_nx   = '0;
            w_cnt_nx   = '0;
        end else if (en_i) begin
            if (r_cnt == w_last) begin
                w_state_nx = S_IDLE;
                w_acc_nx   = '0;
                w_cnt_nx   = '0;
                w_out_nx   = w_result;
                w_valid_nx = 1'b1;
            end else begin
                w_state_nx = S_ACC;
                w_acc_nx   = w_sum;
                w_cnt_nx   = r_cnt + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_acc   <= w_acc_nx;
            r_cnt   <= w_cnt_nx;
            r_out   <= w_out_nx;
            r_valid <= w_valid_nx;
        end
        r_l <= w_l_eff;
    end

    assign out_o   = r_out;
    assign valid_o = r_valid;

endmodule
`default_nettype wire
